// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants.
// The receiver and the transmitter both use this package.
package uart_pkg;

   typedef enum logic [2:0] {
      s_IDLE         = 3'd0,
      s_RX_START_BIT = 3'd1,
      s_RX_DATA_BITS = 3'd2,
      s_RX_STOP_BIT  = 3'd3,
      s_CLEANUP      = 3'd4
   } uart_state_t;

   localparam int   CLKS_PER_BIT_DEFAULT = 868;
   localparam int   DATA_BITS            = 8;
   localparam logic START_LVL            = 1'b0;
   localparam logic STOP_LVL             = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL is chosen so the synchronized signal rests at the input's idle level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the raw input through two flops; q is safe to use in CLK domain.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/receiver.sv
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, idle high.
// Each bit is sampled once at its midpoint, timed from the detected start edge.
//
// Output handshake: Rx_DV_out is a one-cycle strobe with no back-pressure;
// the consumer must take Rx_Byte_out in the cycle Rx_DV_out is high (the byte
// itself stays held until the next good frame). Frame_Err_out is a one-cycle
// strobe on a low stop bit and never coincides with Rx_DV_out.
module receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        Rx_Serial_in,
   output logic        Rx_DV_out,
   output logic [7:0]  Rx_Byte_out,
   output logic        Rx_Active_out,
   output logic        Frame_Err_out,
   output uart_state_t Rx_State_out
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int               H        = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

   logic             line;
   uart_state_t      state,   state_n;
   logic [CNT_W-1:0] count,   count_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift,   shift_n;
   logic [7:0]       byte_q,  byte_n;
   logic             dv_q,    dv_n;
   logic             err_q,   err_n;
   // armed drops after a framing error so a held-low break cannot look like
   // an endless stream of start bits; the line must return high first.
   logic             armed,   armed_n;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .d     (Rx_Serial_in),
      .q     (line)
   );

   // State and datapath registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= s_IDLE;
         count   <= '0;
         bit_idx <= '0;
         shift   <= '0;
         byte_q  <= '0;
         dv_q    <= 1'b0;
         err_q   <= 1'b0;
         armed   <= 1'b1;
      end else begin
         state   <= state_n;
         count   <= count_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         byte_q  <= byte_n;
         dv_q    <= dv_n;
         err_q   <= err_n;
         armed   <= armed_n;
      end
   end

   // Next-state logic: bit timing, sampling, and the one-cycle result strobes.
   always_comb begin
      state_n   = state;
      count_n   = count;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      byte_n    = byte_q;
      dv_n      = 1'b0;
      err_n     = 1'b0;
      armed_n   = armed;

      case (state)
         s_IDLE: begin
            count_n   = '0;
            bit_idx_n = '0;
            if (line == STOP_LVL) begin
               armed_n = 1'b1;
            end else if (armed) begin
               state_n = s_RX_START_BIT;
            end
         end

         s_RX_START_BIT: begin
            if (count == H_LAST) begin
               count_n = '0;
               // A high midpoint means the low pulse was a glitch.
               state_n = (line == START_LVL) ? s_RX_DATA_BITS : s_IDLE;
            end else begin
               count_n = count + 1'b1;
            end
         end

         s_RX_DATA_BITS: begin
            if (count == BIT_LAST) begin
               count_n          = '0;
               shift_n[bit_idx] = line;
               if (bit_idx == IDX_LAST) begin
                  bit_idx_n = '0;
                  state_n   = s_RX_STOP_BIT;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               count_n = count + 1'b1;
            end
         end

         s_RX_STOP_BIT: begin
            if (count == BIT_LAST) begin
               count_n = '0;
               state_n = s_CLEANUP;
               if (line == STOP_LVL) begin
                  byte_n = shift;
                  dv_n   = 1'b1;
               end else begin
                  err_n   = 1'b1;
                  armed_n = 1'b0;
               end
            end else begin
               count_n = count + 1'b1;
            end
         end

         s_CLEANUP: begin
            state_n = s_IDLE;
         end

         default: begin
            // Unreachable encodings recover like reset but keep the last byte.
            state_n   = s_IDLE;
            count_n   = '0;
            bit_idx_n = '0;
            armed_n   = 1'b1;
         end
      endcase
   end

   assign Rx_DV_out     = dv_q;
   assign Frame_Err_out = err_q;
   assign Rx_Byte_out   = byte_q;
   assign Rx_State_out  = state;
   assign Rx_Active_out = (state == s_RX_START_BIT) ||
                          (state == s_RX_DATA_BITS) ||
                          (state == s_RX_STOP_BIT);

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver at 16 clocks per bit: a table of single frames, then
// hand-written glitch, framing-error, mid-frame reset and loopback sequences.
module tb_receiver;
   import uart_pkg::*;

   localparam int CPB = 16;

   // ---------------- clock / reset ----------------
   logic        CLK = 1'b0;
   logic        RST_N;
   logic        rx_line;
   logic        Rx_DV_out;
   logic [7:0]  Rx_Byte_out;
   logic        Rx_Active_out;
   logic        Frame_Err_out;
   uart_state_t Rx_State_out;

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   receiver #(.CLKS_PER_BIT(CPB)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .Rx_Serial_in  (rx_line),
      .Rx_DV_out     (Rx_DV_out),
      .Rx_Byte_out   (Rx_Byte_out),
      .Rx_Active_out (Rx_Active_out),
      .Frame_Err_out (Frame_Err_out),
      .Rx_State_out  (Rx_State_out)
   );

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- counters / scoreboard ----------------
   int n_vec = 0;
   int n_bad = 0;
   int dv_cnt = 0;
   int act_cnt = 0;
   int last_dv_cyc = 0;
   logic [7:0] last_good = 8'h00;
   // Each entry is {expect_error, byte_on_Rx_Byte_out}.
   logic [8:0] exp_q[$];
   logic [8:0] exp_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Monitor: pop on every DV or error strobe.
   always @(negedge CLK) begin
      if (RST_N === 1'b1) begin
         if (Rx_DV_out && Frame_Err_out) begin
            n_vec++;
            n_bad++;
            $display("FAIL dv_err_overlap: both strobes high at cycle %0d", cyc);
         end
         if (Rx_DV_out || Frame_Err_out) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_strobe: dv=%b err=%b byte=%h, expected none",
                        Rx_DV_out, Frame_Err_out, Rx_Byte_out);
            end else begin
               exp_e = exp_q.pop_front();
               if ({Frame_Err_out, Rx_Byte_out} !== exp_e) begin
                  n_bad++;
                  $display("FAIL strobe_data: got err=%b byte=%h, expected err=%b byte=%h",
                           Frame_Err_out, Rx_Byte_out, exp_e[8], exp_e[7:0]);
               end
            end
            if (Rx_DV_out) begin
               dv_cnt++;
               last_dv_cyc = cyc;
            end
         end
         if (Rx_Active_out) act_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   // Bit j of the frame (0 = start, 9 = stop) lasts w_even or w_odd cycles by
   // parity of j. rst_bit >= 0 resets both ends halfway through that bit.
   task automatic send_frame(input logic [7:0] data, input int w_even, input int w_odd,
                             input logic stop_lvl, input int rst_bit);
      for (int j = 0; j < 10; j++) begin
         logic lvl;
         int   w;
         if (j == 0)      lvl = 1'b0;
         else if (j == 9) lvl = stop_lvl;
         else             lvl = data[j-1];
         w = (j % 2 == 0) ? w_even : w_odd;
         rx_line = lvl;
         for (int c = 0; c < w; c++) begin
            if (j == rst_bit && c == w / 2) begin
               RST_N = 1'b0;
               @(posedge CLK); #1;
               RST_N   = 1'b1;
               rx_line = 1'b1;
               return;
            end
            @(posedge CLK); #1;
         end
      end
   endtask

   task automatic idle(input int n);
      rx_line = 1'b1;
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         @(posedge CLK); #1;
      end
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      int         w_even;
      int         w_odd;
      int         gap;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int t0;
      int dv0;

      vecs[0] = '{8'hA5, 16, 16, 30, 8'hA5};
      vecs[1] = '{8'h00, 16, 16, 30, 8'h00};
      vecs[2] = '{8'hFF, 16, 16, 30, 8'hFF};
      vecs[3] = '{8'h5A, 16, 16, 30, 8'h5A};
      vecs[4] = '{8'h01, 16, 16, 30, 8'h01};
      vecs[5] = '{8'h80, 16, 16, 30, 8'h80};
      vecs[6] = '{8'hC3, 17, 17, 30, 8'hC3};
      vecs[7] = '{8'hC3, 15, 15, 30, 8'hC3};

      // Reset state.
      RST_N   = 1'b0;
      rx_line = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_dv",     32'(Rx_DV_out),     32'd0);
      check("rst_byte",   32'(Rx_Byte_out),   32'h00);
      check("rst_active", 32'(Rx_Active_out), 32'd0);
      check("rst_err",    32'(Frame_Err_out), 32'd0);
      check("rst_state",  32'(Rx_State_out),  32'(s_IDLE));
      RST_N = 1'b1;
      idle(10);
      check("idle_state", 32'(Rx_State_out), 32'(s_IDLE));

      // Table of single good frames, including +/-1 clock per bit skew.
      for (int i = 0; i < 8; i++) begin
         t0      = cyc;
         dv0     = dv_cnt;
         act_cnt = 0;
         exp_q.push_back({1'b0, vecs[i].exp_byte});
         send_frame(vecs[i].data, vecs[i].w_even, vecs[i].w_odd, 1'b1, -1);
         wait_drain("vec", 400);
         check("vec_byte", 32'(Rx_Byte_out), 32'(vecs[i].exp_byte));
         check("vec_dv_count", 32'(dv_cnt - dv0), 32'd1);
         // Pin fall to DV: 2 + 1 + H + 9*CPB + 1 = 156, within one cycle.
         check_range("vec_latency", last_dv_cyc - t0, 155, 157);
         check_range("vec_active_cycles", act_cnt, 145, 165);
         check("vec_err_low", 32'(Frame_Err_out), 32'd0);
         last_good = vecs[i].exp_byte;
         idle(vecs[i].gap);
      end

      // Short low glitch: start is rejected at the midpoint.
      dv0     = dv_cnt;
      act_cnt = 0;
      rx_line = 1'b0;
      repeat (5) begin
         @(posedge CLK); #1;
      end
      idle(30);
      check_range("glitch_active_seen", act_cnt, 1, 20);
      check("glitch_active_low", 32'(Rx_Active_out), 32'd0);
      check("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);
      check("glitch_state", 32'(Rx_State_out), 32'(s_IDLE));

      // Framing error, then a held-low break, then a good frame.
      exp_q.push_back({1'b1, last_good});
      send_frame(8'h3C, 16, 16, 1'b0, -1);
      act_cnt = 0;
      repeat (40) begin
         @(posedge CLK); #1;
      end
      check("break_no_restart", 32'(act_cnt), 32'd0);
      check("ferr_seen", 32'(exp_q.size()), 32'd0);
      check("ferr_byte_held", 32'(Rx_Byte_out), 32'(last_good));
      idle(20);
      exp_q.push_back({1'b0, 8'h81});
      send_frame(8'h81, 16, 16, 1'b1, -1);
      wait_drain("after_break", 400);
      check("after_break_byte", 32'(Rx_Byte_out), 32'h81);
      last_good = 8'h81;
      idle(30);

      // Reset during data bit 4 (frame bit 5) of 0x55.
      dv0 = dv_cnt;
      send_frame(8'h55, 16, 16, 1'b1, 5);
      check("midrst_byte",   32'(Rx_Byte_out),   32'h00);
      check("midrst_dv",     32'(Rx_DV_out),     32'd0);
      check("midrst_active", 32'(Rx_Active_out), 32'd0);
      check("midrst_err",    32'(Frame_Err_out), 32'd0);
      check("midrst_state",  32'(Rx_State_out),  32'(s_IDLE));
      last_good = 8'h00;
      idle(200);
      check("midrst_no_dv", 32'(dv_cnt - dv0), 32'd0);
      exp_q.push_back({1'b0, 8'h96});
      send_frame(8'h96, 16, 16, 1'b1, -1);
      wait_drain("after_rst", 400);
      check("after_rst_byte", 32'(Rx_Byte_out), 32'h96);
      idle(30);

      // Loopback: 256 frames back-to-back with no idle between them.
      dv0 = dv_cnt;
      for (int b = 0; b < 256; b++) begin
         exp_q.push_back({1'b0, 8'(b)});
         send_frame(8'(b), CPB, CPB, 1'b1, -1);
      end
      wait_drain("loopback", 1000);
      check("loopback_dv_count", 32'(dv_cnt - dv0), 32'd256);
      check("loopback_last_byte", 32'(Rx_Byte_out), 32'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- UART receiver: deserializes one serial line into 8-bit bytes.
- Frame format is 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); idle line is high.
- Pairs with the existing UART transmitter on the same CLKS_PER_BIT, and feeds received bytes (e.g. AES key/plaintext) into the core-side byte loader.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (f_CLK / baud); legal range 4..2047.
- Derived constant H = CLKS_PER_BIT/2 (floor), the cycles from start detection to the start-bit midpoint.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST_N  input  1  synchronous active-low reset
- Rx_Serial_in  input  1  asynchronous serial line, idle high
- Rx_DV_out  output  1  one-cycle pulse: Rx_Byte_out holds a new valid byte
- Rx_Byte_out  output  8  last correctly framed byte; held until the next valid byte
- Rx_Active_out  output  1  high from start detection until the frame ends
- Frame_Err_out  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset: one clock; reset is synchronous and active-low (RST_N sampled on rising CLK).
- While RST_N=0:
  - Rx_DV_out=0, Rx_Byte_out=8'h00, Rx_Active_out=0, Frame_Err_out=0.
  - Synchronizer flops = 1, counters = 0, state = IDLE, armed = 1.
- Reset mid-frame aborts the frame; no DV or error pulse is produced.
- Input synchronizer: 2 flops; "line" means the output of the second flop. Pin-to-line delay is 2 cycles.
- Clock_Count width is clog2(CLKS_PER_BIT) bits; Bit_Index is 3 bits.
- IDLE:
  - line=1 sets armed=1.
  - line=0 with armed=1 goes to START, with Clock_Count=0 and Rx_Active_out=1 on the next cycle.
- START:
  - Count to H-1, then sample line.
  - Sample 0: Clock_Count=0, go to DATA.
  - Sample 1 (glitch or false start): go to IDLE, Rx_Active_out=0, no pulses.
- DATA:
  - Count to CLKS_PER_BIT-1, then shift the sampled line into bit Bit_Index (LSB first), clear the count, increment the index.
  - After bit 7, go to STOP with index = 0.
  - Data bit k is sampled H + (k+1)*CLKS_PER_BIT cycles after start detection.
- STOP: count to CLKS_PER_BIT-1, then sample line.
  - Sample 1: Rx_Byte_out <= shift register and Rx_DV_out=1 in the same cycle, for exactly one cycle.
  - Sample 0: Frame_Err_out=1 for one cycle, Rx_Byte_out unchanged, armed=0 (a held-low break must go high before a new start is accepted).
  - Either way, go to CLEANUP.
- CLEANUP:
  - One cycle; pulses drop, Rx_Active_out=0, go to IDLE.
  - Frames are accepted back-to-back: the second half of the stop bit absorbs CLEANUP.
- Rx_DV_out and Frame_Err_out are never high together.
- Latency, pin falling edge to Rx_DV_out rising: 2 + 1 + H + 9*CLKS_PER_BIT + 1 cycles, within ±1 cycle.
- Illegal state encoding: return to IDLE with outputs as in reset, except Rx_Byte_out is held.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings s_IDLE=0, s_RX_START_BIT=1, s_RX_DATA_BITS=2, s_RX_STOP_BIT=3, s_CLEANUP=4;
  - default CLKS_PER_BIT=868;
  - frame constants DATA_BITS=8, START_LVL=0, STOP_LVL=1.
  - The transmitter shares these.
- One sub-module: sync_2ff (parameterizable reset value, default 1), also reusable for other async inputs.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 (ideal timing) -> one Rx_DV_out pulse, Rx_Byte_out=0xA5, Frame_Err_out stays 0, Rx_Active_out high for about 160 cycles.
- Transmitter-to-receiver loopback, 256 bytes 0x00..0xFF back-to-back (Tx_DV at each Tx_Done) -> 256 DV pulses in order, all bytes match, no errors.
- Line low for 5 cycles (< H=8) then high -> START aborts to IDLE, no DV, no error, Rx_Active_out returns to 0.
- Send 0x3C with stop bit forced low, then hold line low 40 cycles, then high, then send 0x81 -> one Frame_Err_out pulse, Rx_Byte_out stays at its prior value, no false restart while low, then DV with 0x81.
- Assert RST_N=0 for 1 cycle during data bit 4 of 0x55, then send 0x96 -> no pulses for the aborted frame, all outputs at reset values, next DV with 0x96.
- Baud skew: transmit 0xC3 at 16±1 clocks per bit (±6%) -> DV with 0xC3 in both cases.
